// File: rtl/keystroke_sequencer_if.sv
// Scan-byte input, decoder nibble/letter exchange and letter FIFO handshake
// between keystroke_sequencer (slave) and its environment (master).
interface keystroke_sequencer_if;
  logic [7:0] scan_byte;
  logic       scan_valid;
  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [4:0] letter_in;
  logic [4:0] letter_out;
  logic       letter_valid;
  logic       letter_ready;
  logic       key_held;
  logic       overflow;

  modport master (
    output scan_byte, scan_valid, letter_in, letter_ready,
    input  dig1, dig2, letter_out, letter_valid, key_held, overflow
  );

  modport slave (
    input  scan_byte, scan_valid, letter_in, letter_ready,
    output dig1, dig2, letter_out, letter_valid, key_held, overflow
  );
endinterface

// File: rtl/keystroke_sequencer.sv
// PS/2 scan-code parser: strips break/extended sequences, suppresses typematic
// repeats, looks up make codes through the external decoder and queues letters.
module keystroke_sequencer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  keystroke_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W      = PTR_W + 1;
  localparam logic [7:0]  BYTE_BREAK = 8'hF0;
  localparam logic [7:0]  BYTE_EXT   = 8'hE0;

  typedef enum logic [2:0] {
    S_IDLE, S_BREAK, S_EXT, S_EXT_BREAK, S_LOOKUP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       held_q, held_d;
  logic             key_held_q, key_held_d;
  logic [3:0]       dig1_q, dig1_d;
  logic [3:0]       dig2_q, dig2_d;
  logic             overflow_q, overflow_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [4:0]       mem_q [DEPTH];
  logic [4:0]       mem_d [DEPTH];

  logic is_make_c, accept_c, push_c, pop_c, full_c, push_ok_c;

  // A make is a byte with high nibble 1..4 that is not a repeat of the held key.
  assign is_make_c = (bus.scan_byte[7:4] >= 4'h1) && (bus.scan_byte[7:4] <= 4'h4);
  assign accept_c  = bus.scan_valid && is_make_c &&
                     !(key_held_q && (bus.scan_byte == held_q));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.scan_valid) begin
          if (bus.scan_byte == BYTE_BREAK)    state_d = S_BREAK;
          else if (bus.scan_byte == BYTE_EXT) state_d = S_EXT;
          else if (accept_c)                  state_d = S_LOOKUP;
        end
      end
      S_BREAK:     if (bus.scan_valid) state_d = S_IDLE;
      S_EXT: begin
        if (bus.scan_valid)
          state_d = (bus.scan_byte == BYTE_BREAK) ? S_EXT_BREAK : S_IDLE;
      end
      S_EXT_BREAK: if (bus.scan_valid) state_d = S_IDLE;
      S_LOOKUP:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    held_d     = held_q;
    key_held_d = key_held_q;
    dig1_d     = dig1_q;
    dig2_d     = dig2_q;
    push_c     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          held_d     = bus.scan_byte;
          key_held_d = 1'b1;
          dig2_d     = bus.scan_byte[7:4];
          dig1_d     = bus.scan_byte[3:0];
        end
      end
      S_BREAK: begin
        if (bus.scan_valid && (bus.scan_byte == held_q)) key_held_d = 1'b0;
      end
      S_LOOKUP: push_c = 1'b1;
      default: ;
    endcase
  end

  // Letter FIFO: a full push only lands when a pop frees a slot in the same cycle.
  assign full_c    = (count_q == CNT_W'(DEPTH));
  assign pop_c     = bus.letter_ready && (count_q != '0);
  assign push_ok_c = push_c && (!full_c || pop_c);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_c && full_c && !pop_c);
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = bus.letter_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok_c && !pop_c)      count_d = count_q + CNT_W'(1);
    else if (!push_ok_c && pop_c) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q     <= '0;
      key_held_q <= 1'b0;
      dig1_q     <= '0;
      dig2_q     <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      mem_q      <= '{default: '0};
    end else begin
      held_q     <= held_d;
      key_held_q <= key_held_d;
      dig1_q     <= dig1_d;
      dig2_q     <= dig2_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      mem_q      <= mem_d;
    end
  end

  assign bus.dig1         = dig1_q;
  assign bus.dig2         = dig2_q;
  assign bus.key_held     = key_held_q;
  assign bus.overflow     = overflow_q;
  assign bus.letter_valid = (count_q != '0);
  assign bus.letter_out   = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_keystroke_sequencer.sv
// Scoreboard bench for keystroke_sequencer with a combinational decoder stub.
module tb_keystroke_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   pops  = 0;
  logic [4:0] sb [$];

  always #5 clk = ~clk;

  keystroke_sequencer_if bus ();

  keystroke_sequencer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [4:0] dec(input logic [7:0] code);
    case (code)
      8'h1C:   dec = 5'd0;
      8'h24:   dec = 5'd4;
      8'h15:   dec = 5'd16;
      8'h1D:   dec = 5'd22;
      8'h2D:   dec = 5'd17;
      8'h2C:   dec = 5'd19;
      8'h35:   dec = 5'd24;
      default: dec = 5'd31;
    endcase
  endfunction

  assign bus.letter_in = dec({bus.dig2, bus.dig1});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted FIFO pop must match the oldest expected letter.
  always @(negedge clk) begin
    if (!reset && bus.letter_valid && bus.letter_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check("unexpected_letter", {27'd0, bus.letter_out}, 32'hFFFF_FFFF);
      end else begin
        check("letter_order", {27'd0, bus.letter_out}, {27'd0, sb.pop_front()});
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    bus.scan_byte  = b;
    bus.scan_valid = 1'b1;
    tick();
    bus.scan_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit queued);
    if (queued) sb.push_back(dec(b));
    strobe(b);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int p0;
    reset            = 1'b1;
    bus.scan_byte    = '0;
    bus.scan_valid   = 1'b0;
    bus.letter_ready = 1'b0;
    tick(2);
    reset = 1'b0;

    check("rst_valid",    bus.letter_valid, 0);
    check("rst_key_held", bus.key_held,     0);
    check("rst_overflow", bus.overflow,     0);
    check("rst_dig1",     bus.dig1,         0);
    check("rst_dig2",     bus.dig2,         0);
    check("rst_out",      bus.letter_out,   0);
    bus.letter_ready = 1'b1;
    tick(10);
    check("empty_ready_valid", bus.letter_valid, 0);
    bus.letter_ready = 1'b0;

    // Basic make 0x1C: digits in N+1, letter visible in N+2.
    sb.push_back(dec(8'h1C));
    strobe(8'h1C);
    check("mk_dig2",        bus.dig2,         4'h1);
    check("mk_dig1",        bus.dig1,         4'hC);
    check("mk_no_fallthru", bus.letter_valid, 0);
    tick();
    check("mk_valid", bus.letter_valid, 1);
    check("mk_out",   bus.letter_out,   0);
    bus.letter_ready = 1'b1;
    tick();
    bus.letter_ready = 1'b0;
    check("mk_popped", bus.letter_valid, 0);

    // Typematic repeats and release.
    bus.letter_ready = 1'b1;
    send(8'h24, 1);
    check("tm_held", bus.key_held, 1);
    send(8'h24, 0);
    send(8'h24, 0);
    check("tm_still_held", bus.key_held, 1);
    send(8'hF0, 0);
    send(8'h24, 0);
    check("tm_released", bus.key_held, 0);
    send(8'h24, 1);
    check("tm_held_again", bus.key_held, 1);
    tick(2);
    check("tm_sb_empty", sb.size(), 0);

    // Extended sequences never reach the decoder.
    send(8'hF0, 0);
    send(8'h24, 0);
    send(8'hE0, 0);
    send(8'h75, 0);
    send(8'hE0, 0);
    send(8'hF0, 0);
    send(8'h75, 0);
    check("ext_key_held", bus.key_held, 0);
    check("ext_dig",      {bus.dig2, bus.dig1}, 8'h24);
    send(8'h1C, 1);
    check("ext_1c_held", bus.key_held, 1);
    tick(2);
    check("ext_sb_empty", sb.size(), 0);
    bus.letter_ready = 1'b0;

    // Overflow with consumer stalled.
    send(8'h15, 1);
    send(8'h1D, 1);
    send(8'h24, 1);
    send(8'h2D, 1);
    check("ov_not_yet", bus.overflow, 0);
    send(8'h2C, 0);
    check("ov_set", bus.overflow, 1);
    send(8'h35, 0);
    check("ov_valid", bus.letter_valid, 1);
    check("ov_head",  bus.letter_out,   dec(8'h15));
    // Push coincident with pop while full.
    sb.push_back(dec(8'h1C));
    strobe(8'h1C);
    bus.letter_ready = 1'b1;
    tick();
    bus.letter_ready = 1'b0;
    check("ov_sticky",   bus.overflow,   1);
    check("ov_new_head", bus.letter_out, dec(8'h1D));
    p0 = pops;
    bus.letter_ready = 1'b1;
    tick(8);
    bus.letter_ready = 1'b0;
    check("ov_drain_count", pops - p0, 4);
    check("ov_sb_empty",    sb.size(), 0);
    check("ov_drained",     bus.letter_valid, 0);

    // Reset mid-break sequence.
    strobe(8'hF0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_overflow", bus.overflow,     0);
    check("mr_valid",    bus.letter_valid, 0);
    check("mr_key_held", bus.key_held,     0);
    bus.letter_ready = 1'b1;
    send(8'h1C, 1);
    tick(3);
    check("mr_key_held_1c", bus.key_held, 1);
    check("mr_sb_empty",    sb.size(),    0);
    bus.letter_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keystroke_sequencer.md
Name: keystroke_sequencer

Overview:
- Sits between the PS/2 byte receiver and the combinational keycode decoder.
- Parses the scan-code stream: strips break (F0) and extended (E0) sequences and suppresses typematic repeats of a held key.
- Presents each accepted make code to the decoder as two nibbles and captures the returned 5-bit letter code.
- Queues letter codes in a small FIFO with a valid/ready handshake toward the display/game logic.

Parameters:
- DEPTH, 4, letter FIFO entries (power of 2, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- scan_byte  in  8  completed PS/2 byte from receiver
- scan_valid  in  1  one-cycle strobe, scan_byte valid
- dig1  out  4  low nibble of make code, to decoder
- dig2  out  4  high nibble of make code, to decoder
- letter_in  in  5  letter code returned by decoder (combinational from dig1/dig2)
- letter_out  out  5  FIFO head letter code
- letter_valid  out  1  FIFO non-empty
- letter_ready  in  1  consumer pops head when letter_valid & letter_ready
- key_held  out  1  a make code is held (no break seen yet)
- overflow  out  1  sticky: a letter was dropped because the FIFO was full

Behaviour:
- One clock; reset is synchronous and active-high. Reset clears state to IDLE and zeroes dig1, dig2, FIFO pointers/count, held_code, key_held and overflow. letter_valid=0; letter_out=0.
- Reset mid-sequence (e.g. in BREAK or LOOKUP) discards the partial sequence, and no push occurs.
- FSM states: IDLE, BREAK, EXT, EXT_BREAK, LOOKUP. Transitions are evaluated only on scan_valid, except LOOKUP.
- IDLE:
  - byte F0 -> BREAK
  - byte E0 -> EXT
  - byte with high nibble 1..4 -> make handling
  - any other byte -> dropped, stay IDLE
- Make handling:
  - If key_held and byte==held_code: typematic repeat, ignored, stay IDLE.
  - Otherwise: held_code<=byte, key_held<=1, dig2<=byte[7:4], dig1<=byte[3:0], -> LOOKUP.
- LOOKUP (exactly one cycle): sample letter_in, push it to the FIFO, -> IDLE. scan_valid arriving during LOOKUP is dropped.
- BREAK:
  - next byte == held_code -> key_held<=0.
  - any other byte -> no change.
  - -> IDLE in both cases.
- EXT:
  - byte F0 -> EXT_BREAK.
  - any other byte -> dropped, -> IDLE.
- EXT_BREAK: next byte dropped, -> IDLE. Extended keys never reach the decoder or affect key_held.
- Latency: make byte strobed in cycle N -> dig1/dig2 valid in N+1 -> FIFO write at end of N+1 -> letter_valid=1 in N+2 (if FIFO was empty).
- dig1/dig2 hold their last value between lookups.
- FIFO:
  - Registered head; count in 0..DEPTH.
  - Pointers wrap modulo DEPTH.
  - letter_valid = (count!=0); letter_out = mem[rd_ptr].
- Full FIFO:
  - A push without a simultaneous pop is dropped and overflow<=1. overflow stays set until reset.
  - Push with a simultaneous pop while full: both occur, count unchanged, no overflow.
- Empty FIFO: letter_ready ignored, no pointer change. A push into an empty FIFO is not visible until the next cycle (no fall-through).

Test Plan:
- Reset then idle → letter_valid=0, key_held=0, overflow=0, dig1=dig2=0; letter_ready=1 held for 10 cycles → no pointer change.
- Byte 0x1C, decoder stub returns 5'b00000 → dig2=1, dig1=C in N+1; letter_valid=1, letter_out=00000 in N+2; pop → letter_valid=0 next cycle.
- Typematic: 0x24 ×3 then F0 24 → exactly one letter queued, key_held=1 after the first byte and 0 after the break; then 0x24 again → second letter queued.
- Extended: E0 75 and E0 F0 75, then 0x1C → only one letter queued (from 0x1C); key_held tracks 0x1C only.
- Overflow: six distinct makes (15,1D,24,2D,2C,35) with letter_ready=0 → count=4, overflow=1, head=decoder value for 0x15. Then pop coincident with a 7th push while full → count stays 4, FIFO order preserved.
- Reset asserted the cycle after an F0 byte → state IDLE, FIFO empty, overflow cleared; a following 0x1C is treated as a fresh make and queued.
